// File: rtl/simon_auto_player_if.sv
// Game-side bundle for the autoplayer: LED/status inputs toward the player and
// button/status outputs back to the game core.
interface simon_auto_player_if #(
    parameter int unsigned DEPTH = 5
);
    localparam int unsigned LEN_W = $clog2(DEPTH + 1);

    logic             enable;
    logic             LED1_RED;
    logic             LED2_GREEN;
    logic             LED3_BLUE;
    logic [1:0]       LED4_YELLOW;
    logic             allclear;
    logic [3:0]       buttonOut;
    logic             busy;
    logic [LEN_W-1:0] seqLen;
    logic             overflow;

    modport master (
        output enable, LED1_RED, LED2_GREEN, LED3_BLUE, LED4_YELLOW, allclear,
        input  buttonOut, busy, seqLen, overflow
    );

    modport slave (
        input  enable, LED1_RED, LED2_GREEN, LED3_BLUE, LED4_YELLOW, allclear,
        output buttonOut, busy, seqLen, overflow
    );
endinterface

// File: rtl/simon_auto_player.sv
// Colour-memory autoplayer: records LED flashes during the show, then replays
// them as timed one-hot button presses once the LEDs stay dark long enough.
module simon_auto_player #(
    parameter int unsigned DEPTH        = 5,
    parameter int unsigned PRESS_CYCLES = 4,
    parameter int unsigned GAP_CYCLES   = 4,
    parameter int unsigned IDLE_TIMEOUT = 16
) (
    input logic                clock,
    input logic                reset,
    simon_auto_player_if.slave bus
);
    localparam int unsigned LEN_W  = $clog2(DEPTH + 1);
    localparam int unsigned DARK_W = $clog2(IDLE_TIMEOUT + 1);
    localparam int unsigned PH_MAX = (PRESS_CYCLES > GAP_CYCLES) ? PRESS_CYCLES : GAP_CYCLES;
    localparam int unsigned PH_W   = $clog2(PH_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CAPTURE,
        S_PRESS,
        S_GAP,
        S_DONE
    } state_t;

    state_t            r_state;
    logic              r_lit_d;
    logic [1:0]        r_buf [DEPTH];
    logic [LEN_W-1:0]  r_wr_ptr;
    logic [LEN_W-1:0]  r_rd_ptr;
    logic [LEN_W-1:0]  r_seq_len;
    logic [DARK_W-1:0] r_dark_cnt;
    logic [PH_W-1:0]   r_phase_cnt;
    logic [3:0]        r_button;
    logic              r_busy;
    logic              r_overflow;

    logic              w_lit;
    logic              w_flash;
    logic [1:0]        w_code;
    logic [LEN_W-1:0]  w_next_rd;
    logic [LEN_W-1:0]  w_last_rd;

    function automatic logic [3:0] one_hot(input logic [1:0] code);
        return 4'b0001 << code;
    endfunction

    always_comb begin
        w_lit     = bus.LED1_RED | bus.LED2_GREEN | bus.LED3_BLUE | (bus.LED4_YELLOW != 2'b00);
        w_flash   = w_lit & ~r_lit_d;
        w_next_rd = r_rd_ptr + LEN_W'(1);
        w_last_rd = r_seq_len - LEN_W'(1);
        // lowest-numbered colour wins when several LEDs light together
        if (bus.LED1_RED)        w_code = 2'd0;
        else if (bus.LED2_GREEN) w_code = 2'd1;
        else if (bus.LED3_BLUE)  w_code = 2'd2;
        else                     w_code = 2'd3;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_lit_d     <= 1'b0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_seq_len   <= '0;
            r_dark_cnt  <= '0;
            r_phase_cnt <= '0;
            r_button    <= '0;
            r_busy      <= 1'b0;
            r_overflow  <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) r_buf[i] <= '0;
        end else begin
            r_lit_d <= w_lit;
            if (bus.allclear) begin
                r_state  <= S_DONE;
                r_button <= '0;
                r_busy   <= 1'b0;
            end else if (r_state == S_DONE) begin
                r_state <= S_DONE;
            end else if (!bus.enable) begin
                // overflow is deliberately left sticky across an enable drop
                r_state     <= S_IDLE;
                r_button    <= '0;
                r_busy      <= 1'b0;
                r_wr_ptr    <= '0;
                r_rd_ptr    <= '0;
                r_seq_len   <= '0;
                r_dark_cnt  <= '0;
                r_phase_cnt <= '0;
                for (int unsigned i = 0; i < DEPTH; i++) r_buf[i] <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_state    <= S_CAPTURE;
                        r_dark_cnt <= '0;
                    end
                    S_CAPTURE: begin
                        if (w_flash) begin
                            if (r_seq_len < LEN_W'(DEPTH)) begin
                                r_buf[r_wr_ptr] <= w_code;
                                r_wr_ptr        <= r_wr_ptr + LEN_W'(1);
                                r_seq_len       <= r_seq_len + LEN_W'(1);
                            end else begin
                                r_overflow <= 1'b1;
                            end
                        end
                        if (w_lit) begin
                            r_dark_cnt <= '0;
                        end else if (r_seq_len != '0) begin
                            if (r_dark_cnt == DARK_W'(IDLE_TIMEOUT - 1)) begin
                                r_state     <= S_PRESS;
                                r_rd_ptr    <= '0;
                                r_dark_cnt  <= '0;
                                r_phase_cnt <= '0;
                                r_button    <= one_hot(r_buf[0]);
                                r_busy      <= 1'b1;
                            end else begin
                                r_dark_cnt <= r_dark_cnt + DARK_W'(1);
                            end
                        end
                    end
                    S_PRESS: begin
                        if (r_phase_cnt == PH_W'(PRESS_CYCLES - 1)) begin
                            r_state     <= S_GAP;
                            r_phase_cnt <= '0;
                            r_button    <= '0;
                        end else begin
                            r_phase_cnt <= r_phase_cnt + PH_W'(1);
                        end
                    end
                    S_GAP: begin
                        if (r_phase_cnt == PH_W'(GAP_CYCLES - 1)) begin
                            r_phase_cnt <= '0;
                            if (r_rd_ptr == w_last_rd) begin
                                r_state    <= S_CAPTURE;
                                r_seq_len  <= '0;
                                r_wr_ptr   <= '0;
                                r_rd_ptr   <= '0;
                                r_dark_cnt <= '0;
                                r_busy     <= 1'b0;
                            end else begin
                                r_state  <= S_PRESS;
                                r_rd_ptr <= w_next_rd;
                                r_button <= one_hot(r_buf[w_next_rd]);
                            end
                        end else begin
                            r_phase_cnt <= r_phase_cnt + PH_W'(1);
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.buttonOut = r_button;
    assign bus.busy      = r_busy;
    assign bus.seqLen    = r_seq_len;
    assign bus.overflow  = r_overflow;
endmodule

// File: tb/tb_simon_auto_player.sv
// Bench for simon_auto_player: table vectors, hand-written corner sequences and
// randomized shows checked against a colour-list model of the game.
module tb_simon_auto_player;
    localparam int unsigned DEPTH        = 5;
    localparam int unsigned PRESS_CYCLES = 4;
    localparam int unsigned GAP_CYCLES   = 4;
    localparam int unsigned IDLE_TIMEOUT = 16;

    logic clock;
    logic reset;
    int   checks;
    int   failures;

    simon_auto_player_if #(.DEPTH(DEPTH)) bus ();

    simon_auto_player #(
        .DEPTH(DEPTH),
        .PRESS_CYCLES(PRESS_CYCLES),
        .GAP_CYCLES(GAP_CYCLES),
        .IDLE_TIMEOUT(IDLE_TIMEOUT)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // pattern layout: {yellow[1:0], blue, green, red}
    typedef struct {
        logic [4:0] pat;
        logic [3:0] exp_btn;
    } vec_t;

    logic [4:0] show_q[$];
    logic [3:0] exp_q[$];
    logic       exp_ovf;

    task automatic check(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d]: got %0h, want %0h", nm, idx, act, exp);
        end
    endtask

    // first lit colour in red, green, blue, yellow order
    function automatic logic [3:0] model_press(input logic [4:0] p);
        bit         lit[4];
        logic [3:0] m;
        lit[0] = p[0];
        lit[1] = p[1];
        lit[2] = p[2];
        lit[3] = (p[4:3] != 2'b00);
        m = '0;
        for (int c = 3; c >= 0; c--) if (lit[c]) m = 4'b0001 << c;
        return m;
    endfunction

    task automatic drive_leds(input logic [4:0] p);
        bus.LED1_RED    = p[0];
        bus.LED2_GREEN  = p[1];
        bus.LED3_BLUE   = p[2];
        bus.LED4_YELLOW = p[4:3];
    endtask

    task automatic play_show();
        foreach (show_q[i]) begin
            drive_leds(show_q[i]);
            repeat (4) @(negedge clock);
            drive_leds(5'b0);
            repeat (6) @(negedge clock);
        end
        show_q.delete();
    endtask

    task automatic wait_busy(output bit ok);
        int n;
        n = 0;
        while (bus.busy !== 1'b1 && n < 80) begin
            @(negedge clock);
            n++;
        end
        ok = (bus.busy === 1'b1);
        if (!ok) check("busy_timeout", n, {31'b0, bus.busy}, 32'd1);
    endtask

    task automatic replay_check(input bit echo);
        bit ok;
        wait_busy(ok);
        if (ok) begin
            check("seqLen_pre", 0, 32'(bus.seqLen), 32'(exp_q.size()));
            check("overflow", 0, {31'b0, bus.overflow}, {31'b0, exp_ovf});
            foreach (exp_q[k]) begin
                for (int c = 0; c < int'(PRESS_CYCLES); c++) begin
                    check("press", k, {27'b0, bus.busy, bus.buttonOut}, {27'b0, 1'b1, exp_q[k]});
                    if (echo) drive_leds({1'b0, bus.buttonOut[3], bus.buttonOut[2:0]});
                    @(negedge clock);
                end
                drive_leds(5'b0);
                for (int c = 0; c < int'(GAP_CYCLES); c++) begin
                    check("gap", k, {27'b0, bus.busy, bus.buttonOut}, 32'h10);
                    @(negedge clock);
                end
            end
            check("post_busy", 0, {31'b0, bus.busy}, 32'd0);
            check("post_seqLen", 0, 32'(bus.seqLen), 32'd0);
        end
        exp_q.delete();
    endtask

    task automatic model_show();
        foreach (show_q[i]) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(model_press(show_q[i]));
            else exp_ovf = 1'b1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        exp_ovf = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clock);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[10];
        bit   ok;
        int   n;
        logic [4:0] p;

        checks = 0;
        failures = 0;
        exp_ovf = 1'b0;
        reset = 1'b1;
        bus.enable = 1'b0;
        bus.allclear = 1'b0;
        drive_leds(5'b0);

        vecs[0] = '{5'b00001, 4'b0001};
        vecs[1] = '{5'b00010, 4'b0010};
        vecs[2] = '{5'b00100, 4'b0100};
        vecs[3] = '{5'b10000, 4'b1000};
        vecs[4] = '{5'b01000, 4'b1000};
        vecs[5] = '{5'b11000, 4'b1000};
        vecs[6] = '{5'b00101, 4'b0001};
        vecs[7] = '{5'b11110, 4'b0010};
        vecs[8] = '{5'b01100, 4'b0100};
        vecs[9] = '{5'b11111, 4'b0001};

        @(negedge clock);
        check("rst_outputs", 0, {24'b0, bus.buttonOut, bus.busy, 32'(bus.seqLen) != 0, bus.overflow, 1'b0}, 32'd0);
        reset = 1'b0;
        bus.enable = 1'b1;
        repeat (2) @(negedge clock);

        // single-flash shows from the table
        for (int i = 0; i < 10; i++) begin
            show_q.push_back(vecs[i].pat);
            exp_q.push_back(vecs[i].exp_btn);
            play_show();
            replay_check(1'b0);
        end

        // red, blue, yellow(2'b10)
        show_q = '{5'b00001, 5'b00100, 5'b10000};
        exp_q  = '{4'b0001, 4'b0100, 4'b1000};
        play_show();
        replay_check(1'b0);

        // six flashes into a five-deep buffer
        show_q = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b00001, 5'b00010};
        exp_q  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_ovf = 1'b1;
        play_show();
        replay_check(1'b0);

        // enable drop clears the buffer but keeps overflow
        show_q = '{5'b00010, 5'b00100};
        play_show();
        check("seqLen_before_disable", 0, 32'(bus.seqLen), 32'd2);
        bus.enable = 1'b0;
        @(negedge clock);
        check("disable_seqLen", 0, 32'(bus.seqLen), 32'd0);
        check("disable_overflow", 0, {31'b0, bus.overflow}, 32'd1);
        bus.enable = 1'b1;
        repeat (2) @(negedge clock);
        show_q = '{5'b01000};
        exp_q  = '{4'b1000};
        play_show();
        replay_check(1'b0);

        // randomized shows, with the game echoing presses on its LEDs
        for (int s = 0; s < 20; s++) begin
            n = int'($urandom_range(1, 7));
            for (int i = 0; i < n; i++) begin
                p = 5'($urandom);
                if (p == 5'b0) p = 5'b00100;
                show_q.push_back(p);
            end
            model_show();
            play_show();
            replay_check(1'b1);
        end

        // allclear mid-press locks the player in DONE
        do_reset();
        show_q = '{5'b00100, 5'b00010};
        play_show();
        wait_busy(ok);
        repeat (2) @(negedge clock);
        bus.allclear = 1'b1;
        @(negedge clock);
        bus.allclear = 1'b0;
        check("allclear_out", 0, {27'b0, bus.busy, bus.buttonOut}, 32'd0);
        bus.enable = 1'b0;
        @(negedge clock);
        bus.enable = 1'b1;
        show_q = '{5'b00001};
        play_show();
        n = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            if (bus.busy !== 1'b0 || bus.buttonOut !== 4'b0) n++;
        end
        check("done_quiet", 0, 32'(n), 32'd0);

        // async reset mid-gap, then a fresh capture
        do_reset();
        show_q = '{5'b00010};
        play_show();
        wait_busy(ok);
        repeat (PRESS_CYCLES + 1) @(negedge clock);
        check("gap_busy_before_reset", 0, {31'b0, bus.busy}, 32'd1);
        #2 reset = 1'b1;
        #1 check("async_reset_gap", 0, {24'b0, bus.buttonOut, bus.busy, 32'(bus.seqLen) != 0, 2'b0}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        exp_ovf = 1'b0;
        repeat (2) @(negedge clock);
        show_q = '{5'b10000};
        exp_q  = '{4'b1000};
        play_show();
        replay_check(1'b0);

        // async reset mid-press drops the button without a clock edge
        show_q = '{5'b00100};
        play_show();
        wait_busy(ok);
        @(negedge clock);
        check("press_before_reset", 0, 32'(bus.buttonOut), 32'h4);
        #2 reset = 1'b1;
        #1 check("async_reset_press", 0, {27'b0, bus.busy, bus.buttonOut}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/simon_auto_player.md
Name: simon_auto_player

Overview:
- Automated player for the colour-memory game.
- Watches the four game LEDs while the stage sequence is being shown and records each flash as a 2-bit colour code.
- Once the show has gone quiet, it replays the recorded colours as timed one-hot presses on the game's button inputs.
- Sits outside the game core, with its outputs wired to the game's buttonIn; used for self-play demos and closed-loop regression.

Parameters:
- DEPTH, 5: maximum number of colours recorded per show (one per stage).
- PRESS_CYCLES, 4: clocks each button is held high during replay.
- GAP_CYCLES, 4: clocks all buttons are low between presses.
- IDLE_TIMEOUT, 16: consecutive all-dark clocks that mark the end of a show.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- enable  in  1  autoplay enable; when low the FSM is held in IDLE.
- LED1_RED  in  1  game red LED.
- LED2_GREEN  in  1  game green LED.
- LED3_BLUE  in  1  game blue LED.
- LED4_YELLOW  in  2  game yellow LED; counts as lit when nonzero.
- allclear  in  1  game-complete flag from the game core.
- buttonOut  out  4  one-hot press: [0]=red, [1]=green, [2]=blue, [3]=yellow.
- busy  out  1  high in the PRESS and GAP states.
- seqLen  out  clog2(DEPTH+1)  number of recorded entries.
- overflow  out  1  sticky; set when a flash arrives while the buffer is full.

Behaviour:
- Reset (async, active-high) → state=IDLE, buttonOut=0, busy=0, seqLen=0, overflow=0, buffer pointers=0, all counters=0.
- lit = LED1_RED | LED2_GREEN | LED3_BLUE | (LED4_YELLOW != 0).
- lit is registered once to form lit_d. A flash is detected when lit & ~lit_d.
- Colour code is sampled in the flash cycle. Priority encoding when several LEDs are lit: red=0 > green=1 > blue=2 > yellow=3.
- IDLE: outputs zero. If enable=1, go to CAPTURE next cycle.
- CAPTURE:
  - On a flash with seqLen<DEPTH: write the code at wr_ptr, increment wr_ptr and seqLen.
  - On a flash with seqLen==DEPTH: discard it and set overflow.
  - Dark counter: reset to 0 on any lit cycle; otherwise increments while seqLen>0.
  - When the dark counter reaches IDLE_TIMEOUT-1: go to PRESS, rd_ptr=0.
  - With seqLen==0 the block waits indefinitely (no timeout).
- PRESS:
  - buttonOut = one-hot(buf[rd_ptr]); busy=1.
  - After PRESS_CYCLES clocks, go to GAP.
  - LED activity is ignored here (the game echoes presses on its LEDs).
- GAP:
  - buttonOut=0; busy=1; LEDs ignored.
  - After GAP_CYCLES clocks: if rd_ptr==seqLen-1, clear seqLen/wr_ptr/rd_ptr and go to CAPTURE (the next stage re-shows the full sequence). Otherwise increment rd_ptr and go to PRESS.
- DONE:
  - Entered from any state when allclear=1; buttonOut=0, busy=0.
  - Held until reset; enable has no effect in DONE.
- enable=0 in any state other than DONE → next state IDLE, buttonOut=0, buffer cleared, overflow kept.
- Simultaneous events, in priority order: allclear > enable low > normal transition.
- A flash arriving in the same cycle as the timeout expiry: the flash is recorded and the dark counter resets, so there is no transition.
- buttonOut is registered and never has more than one bit set.
- Presses exactly equal PRESS_CYCLES clocks; gaps exactly equal GAP_CYCLES clocks.
- Reset asserted mid-press: buttonOut drops to 0 asynchronously.

Test Plan:
1. reset, enable=1, flash green (4 clks lit, 6 dark), then 16 dark → seqLen=1; then buttonOut=4'b0010 for 4 clks, 0 for 4 clks; then back to CAPTURE with seqLen=0.
2. Flashes red, blue, yellow(LED4_YELLOW=2'b10), then timeout → buttonOut sequence 0001, 0100, 1000, each held 4 clks with 4-clk gaps; busy high throughout.
3. Six flashes with DEPTH=5 → seqLen=5, overflow=1, and only the first five colours replayed.
4. Red and blue lit in the same cycle → code 0 recorded; buttonOut=0001 on replay.
5. allclear pulsed mid-PRESS → buttonOut=0 next clock, state DONE; further flashes and timeouts produce no presses until reset.
6. reset asserted asynchronously mid-GAP → all outputs 0 immediately; after release with enable=1, a fresh capture of one flash replays correctly.
